// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owners, word geometry.
package mem_arb_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker, purely combinational; one-hot grant {d, if}.
// A lone requester always wins; on contention the port not granted last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  arb_owner_t last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (if_req_i && d_req_i) begin
      gnt_o = (last_gnt_i == OWN_D) ? 2'b01 : 2'b10;
    end else if (if_req_i) begin
      gnt_o = 2'b01;
    end else if (d_req_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; grant at T, rvalid at T+MEM_LATENCY+1.
// One access in flight at a time; requesters hold req until gnt, halted blocks new grants only.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in  [0:WORD_BYTES-1],
  input  logic [7:0]  mem_data_out [0:WORD_BYTES-1],
  output logic        mem_write_en
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, last_gnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q, wdata_q, if_rdata_q, d_rdata_q, rd_word;
  logic             we_q, mem_we_q, if_rvalid_q, d_rvalid_q;
  logic [1:0]       pick;
  logic             last_cycle;

  mem_arb_rr u_rr (
    .if_req_i   (if_req),
    .d_req_i    (d_req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick)
  );

  assign last_cycle = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (if_gnt || d_gnt) state_d = ARB_ACCESS;
      ARB_ACCESS: if (last_cycle) state_d = ARB_RESP;
      ARB_RESP:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state_q == ARB_IDLE && !halted) begin
      if_gnt = pick[0];
      d_gnt  = pick[1];
    end
  end

  // Memory bytes are little-endian: byte [i] lands in bits [8i+7:8i].
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rd_word[8*i +: 8] = mem_data_out[i];
      mem_data_in[i]    = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      owner_q     <= OWN_IF;
      last_gnt_q  <= OWN_D;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (if_gnt || d_gnt) begin
            owner_q  <= d_gnt ? OWN_D : OWN_IF;
            addr_q   <= word_align(d_gnt ? d_addr : if_addr);
            we_q     <= d_gnt && d_we;
            mem_we_q <= d_gnt && d_we;
            cnt_q    <= CNT_W'(MEM_LATENCY);
            if (d_gnt) wdata_q <= d_wdata;
          end
        end
        ARB_ACCESS: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_cycle) begin
            if (owner_q == OWN_IF) begin
              if_rdata_q  <= rd_word;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= we_q ? 32'h0 : rd_word;
              d_rvalid_q <= 1'b1;
            end
          end
        end
        ARB_RESP: last_gnt_q <= owner_q;
        default: ;
      endcase
    end
  end

  assign mem_addr     = addr_q;
  assign mem_write_en = mem_we_q;
  assign if_rdata     = if_rdata_q;
  assign if_rvalid    = if_rvalid_q;
  assign d_rdata      = d_rdata_q;
  assign d_rvalid     = d_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk, rst_b, halted;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_write_en;

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];

  bit          pend_if, pend_d, p_we, last_d;
  logic [31:0] p_ia, p_da, p_wd, last_addr;
  int          n_cmp, n_fail;

  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .halted       (halted),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read of the addressed word, write on strobe.
  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[i] = tb_mem[mem_addr[9:2]][8*i +: 8];
  end
  always @(posedge clk) begin
    if (mem_write_en)
      tb_mem[mem_addr[9:2]] <= {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
  end

  function automatic logic [31:0] din_word();
    return {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction from the pending requests, checked cycle by cycle against the model.
  task automatic do_slot(input bit halt_mid);
    bit          win_d, st;
    logic [31:0] ea, er, wd;
    win_d = (pend_if && pend_d) ? !last_d : pend_d;
    st    = win_d && p_we;
    ea    = (win_d ? p_da : p_ia) & 32'hFFFF_FFFC;
    wd    = p_wd;
    er    = st ? 32'h0 : ref_mem[ea[9:2]];

    @(posedge clk); #1;
    halted  = 1'b0;
    if_req  = pend_if; if_addr = p_ia;
    d_req   = pend_d;  d_we = p_we; d_addr = p_da; d_wdata = p_wd;
    @(negedge clk);
    check("if_gnt", 32'(if_gnt), 32'(!win_d));
    check("d_gnt", 32'(d_gnt), 32'(win_d));
    check("mem_addr_idle_hold", mem_addr, last_addr);

    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (win_d) begin
          pend_d = 1'b0; d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
        end else begin
          pend_if = 1'b0; if_req = 1'b0; if_addr = $urandom;
        end
        if (halt_mid) begin
          halted = 1'b1; pend_if = 1'b1; p_ia = $urandom & 32'h3FF;
          if_req = 1'b1; if_addr = p_ia;
        end
      end
      @(negedge clk);
      check("mem_addr_access", mem_addr, ea);
      check("mem_write_en", 32'(mem_write_en), 32'(st && k == 1));
      check("gnt_busy", 32'({if_gnt, d_gnt}), 32'(0));
      check("rvalid_busy", 32'({if_rvalid, d_rvalid}), 32'(0));
      if (st && k == 1) check("mem_data_in", din_word(), wd);
    end

    @(posedge clk); #1;
    @(negedge clk);
    check("if_rvalid", 32'(if_rvalid), 32'(!win_d));
    check("d_rvalid", 32'(d_rvalid), 32'(win_d));
    check("gnt_resp", 32'({if_gnt, d_gnt}), 32'(0));
    check(win_d ? "d_rdata" : "if_rdata", win_d ? d_rdata : if_rdata, er);

    if (st) ref_mem[ea[9:2]] = wd;
    last_d    = win_d;
    last_addr = ea;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[4] = 32'h0000_0013; ref_mem[4] = 32'h0000_0013;

    rst_b = 1'b0; halted = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pend_if = 0; pend_d = 0; p_we = 0; p_ia = '0; p_da = '0; p_wd = '0;
    last_d = 1'b1; last_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_we", 32'(mem_write_en), 32'h0);
    check("rst_din", din_word(), 32'h0);
    check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_gnt", 32'({if_gnt, d_gnt}), 32'h0);

    // Contention after reset: fetch, data, fetch on consecutive slots.
    pend_if = 1; p_ia = 32'h20; pend_d = 1; p_we = 0; p_da = 32'h40;
    do_slot(0);
    pend_if = 1; p_ia = 32'h24;
    do_slot(0);
    pend_d = 1; p_we = 0; p_da = 32'h48;
    do_slot(0);
    do_slot(0);

    // Fetch of 0x10 returning bytes {13,00,00,00}.
    pend_if = 1; p_ia = 32'h10;
    do_slot(0);
    check("fetch_0x10_data", if_rdata, 32'h0000_0013);

    // Store DEADBEEF to 0x104, then misaligned load of 0x103 and a reload of 0x104.
    pend_d = 1; p_we = 1; p_da = 32'h104; p_wd = 32'hDEAD_BEEF;
    do_slot(0);
    check("store_ack_rdata", d_rdata, 32'h0);
    pend_d = 1; p_we = 0; p_da = 32'h103;
    do_slot(0);
    pend_d = 1; p_we = 0; p_da = 32'h105;
    do_slot(0);
    check("reload_0x104", d_rdata, 32'hDEAD_BEEF);

    // Halt during a data load: response still arrives, pending fetch stays blocked.
    pend_d = 1; p_we = 0; p_da = 32'h80;
    do_slot(1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("halt_no_gnt", 32'({if_gnt, d_gnt}), 32'h0);
    end
    do_slot(0);

    // Reset during the first access cycle of a store.
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("abort_gnt", 32'(d_gnt), 32'h1);
    @(posedge clk); #1;
    d_req = 0; d_we = 0; rst_b = 1'b0;
    @(negedge clk);
    check("abort_we_first", 32'(mem_write_en), 32'h1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_we", 32'(mem_write_en), 32'h0);
    check("abort_din", din_word(), 32'h0);
    check("abort_rdata", if_rdata | d_rdata, 32'h0);
    for (int c = 0; c < 4; c++) begin
      check("abort_no_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    ref_mem[32'h200 >> 2] = 32'h1234_5678;
    last_d = 1'b1; last_addr = '0; pend_if = 0; pend_d = 0;

    // Round-robin state was reset too: fetch wins the first contention again.
    pend_if = 1; p_ia = 32'h204; pend_d = 1; p_we = 0; p_da = 32'h200;
    do_slot(0);
    do_slot(0);
    check("abort_store_landed", d_rdata, 32'h1234_5678);

    for (int n = 0; n < 60; n++) begin
      if (!pend_if && $urandom_range(0, 1) == 1) begin
        pend_if = 1; p_ia = $urandom & 32'h3FF;
      end
      if (!pend_d && $urandom_range(0, 1) == 1) begin
        pend_d = 1; p_we = 1'($urandom); p_da = $urandom & 32'h3FF; p_wd = $urandom;
      end
      if (!pend_if && !pend_d) begin
        pend_if = 1; p_ia = $urandom & 32'h3FF;
      end
      do_slot(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single memory port (`mem_addr`, `mem_data_in`, `mem_data_out`, `mem_write_en`) between the core's instruction-fetch path and its load/store path. Each requester gets a grant/response handshake. The block sequences one memory access at a time through a small FSM, with a configurable read latency. It sits between `riscv_core` and the memory model, which lets the core move to multi-cycle fetch/execute.

## Interface
- `MEM_LATENCY`, default 1: cycles from address presentation to valid `mem_data_out`; legal range ≥1.
- `clk` input 1: clock; all logic on rising edge.
- `rst_b` input 1: reset, synchronous, active-low.
- `halted` input 1: core halted; blocks new grants.
- `if_req` input 1: fetch request (read only).
- `if_addr` input 32: fetch byte address.
- `if_gnt` output 1: fetch request accepted this cycle.
- `if_rvalid` output 1: fetch data valid, one-cycle pulse.
- `if_rdata` output 32: fetched word.
- `d_req` input 1: data request.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store word.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: load data valid or store ack, one-cycle pulse.
- `d_rdata` output 32: loaded word; 0 on store ack.
- `mem_addr` output 32: word-aligned memory address.
- `mem_data_in` output 8 ×[0:3]: write bytes.
- `mem_data_out` input 8 ×[0:3]: read bytes.
- `mem_write_en` output 1: memory write strobe.

## Operation
- States: ARB_IDLE, ARB_ACCESS, ARB_RESP.
- ARB_IDLE:
  - If `halted`=0 and any request is present, assert the chosen `*_gnt` combinationally.
  - Latch owner, `{addr[31:2],2'b00}`, `we` (0 for fetch) and wdata.
  - Load the counter with `MEM_LATENCY`, then go to ARB_ACCESS.
- Arbitration:
  - A lone requester always wins.
  - When both request, use round-robin: grant the port not granted last.
  - The last-grant register resets to DATA, so the first contention goes to fetch.
- ARB_ACCESS:
  - `mem_addr` = latched address.
  - `mem_write_en`=1 only on the first ACCESS cycle of a store.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, register `mem_data_out` into the owner's rdata (little-endian: byte [i] → bits [8i+7:8i]), then go to ARB_RESP.
  - Stores capture nothing; their rdata is 0.
- ARB_RESP: pulse the owner's `*_rvalid` for one cycle, update last-grant, then go to ARB_IDLE. No grant is issued in this state.
- `mem_data_in[i]` = latched `wdata[8i+7:8i]`. It is driven from the latch register in all states.
- Requesters hold req/addr/wdata stable until their gnt. After gnt they may drop or change them.
- `halted`: an in-flight access completes normally, including rvalid. No new grant is issued while `halted`=1.
- Reset: registered outputs go to 0 on the next edge (`mem_addr`, `mem_data_in`, rdata, rvalid, `mem_write_en`), and the FSM goes to ARB_IDLE. An aborted access produces no rvalid.
- `mem_addr` holds its last value while in IDLE.

## Timing
- Request accepted at cycle T (gnt high at T):
  - ACCESS runs T+1 … T+MEM_LATENCY.
  - rvalid at T+MEM_LATENCY+1.
  - Next possible gnt at T+MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Gnt is combinational from req, state and `halted`. All other outputs are registered.
- Counter width: `$clog2(MEM_LATENCY+1)`.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_ACCESS, ARB_RESP}.
  - owner enum `arb_owner_t` {OWN_IF, OWN_D}.
  - localparam `WORD_BYTES`=4.
- Sub-module `mem_arb_rr`: a 2-way round-robin picker. Inputs: two reqs and last-grant. Outputs: one-hot grant. It is combinational and used once.

## Test plan
- Fetch read, MEM_LATENCY=2: `if_req`, `if_addr`=0x10 at T, memory returns bytes {13,00,00,00}. Expect `if_gnt`@T, `mem_addr`=0x10 @T+1..T+2, `if_rvalid`@T+3 with `if_rdata`=0x00000013.
- Store: `d_we`=1, `d_addr`=0x104, `d_wdata`=0xDEADBEEF. Expect `mem_write_en` high only @T+1, `mem_data_in`[0..3]={EF,BE,AD,DE}, `d_rvalid`@T+3 with `d_rdata`=0.
- Contention after reset: `if_req` and `d_req` held high. Expect fetch granted @T, data granted @T+4, fetch again @T+8.
- Halt: `halted` rises during a data load's ACCESS. Expect `d_rvalid` still delivered; a pending `if_req` is never granted.
- Reset mid-access: `rst_b`=0 during the first ACCESS cycle of a store. Expect the next cycle in IDLE with all outputs 0 and no `d_rvalid`.
- Misaligned: `d_addr`=0x103 load. Expect `mem_addr`=0x100.
